// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit (MULT, MULTU, DIV, DIVU) returning {HI, LO}.
// Defining MDU_FAST_MUL_EN gives MULT/MULTU a single-cycle combinational path.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);
  // state   | meaning
  // IDLE    | waiting for start_i; result_o keeps its last value
  // BUSY    | one shift-add or restoring-divide step per cycle
  // DIVZERO | divisor was zero; one cycle, then DONE
  // DONE    | ready_o high until start_i drops
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] DIVZERO = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               div_zero_q, div_zero_d;

  logic               sign1, sign2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               no_borrow;
  logic [WIDTH-1:0]   iter_acc, iter_lo;
  logic [2*WIDTH-1:0] iter_prod, final_res;

  assign sign1 = ~op_i[0] & opdata1_i[WIDTH-1];
  assign sign2 = ~op_i[0] & opdata2_i[WIDTH-1];
  assign mag1  = sign1 ? -opdata1_i : opdata1_i;
  assign mag2  = sign2 ? -opdata2_i : opdata2_i;

  // lo_q holds the multiplier (shifted out) or the dividend (quotient shifted in)
  assign mul_sum   = {1'b0, acc_q} + {1'b0, opb_q};
  assign rem_sh    = {acc_q, lo_q[WIDTH-1]};
  assign no_borrow = rem_sh >= {1'b0, opb_q};
  assign div_diff  = rem_sh[WIDTH-1:0] - opb_q;

  always_comb begin
    if (is_div_q) begin
      iter_acc = no_borrow ? div_diff : rem_sh[WIDTH-1:0];
      iter_lo  = {lo_q[WIDTH-2:0], no_borrow};
    end else if (lo_q[0]) begin
      iter_acc = mul_sum[WIDTH:1];
      iter_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      iter_acc = {1'b0, acc_q[WIDTH-1:1]};
      iter_lo  = {acc_q[0], lo_q[WIDTH-1:1]};
    end
  end

  assign iter_prod = {iter_acc, iter_lo};
  assign final_res = is_div_q ? {(neg_rem_q ? -iter_acc : iter_acc), (neg_res_q ? -iter_lo : iter_lo)}
                              : (neg_res_q ? -iter_prod : iter_prod);

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_mag, fast_prod;
  assign fast_mag  = (2*WIDTH)'(mag1) * (2*WIDTH)'(mag2);
  assign fast_prod = (sign1 ^ sign2) ? -fast_mag : fast_mag;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    acc_d      = acc_q;
    lo_d       = lo_q;
    opb_d      = opb_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;
    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          is_div_d  = op_i[1];
          neg_res_d = sign1 ^ sign2;
          neg_rem_d = sign1;
          acc_d     = '0;
          lo_d      = op_i[1] ? mag1 : mag2;
          opb_d     = op_i[1] ? mag2 : mag1;
          cnt_d     = '0;
          if (op_i[1] && opdata2_i == '0) begin
            state_d = DIVZERO;
          end else begin
            state_d = BUSY;
`ifdef MDU_FAST_MUL_EN
            if (!op_i[1]) begin
              result_d = fast_prod;
              state_d  = DONE;
            end
`endif
          end
        end
      end
      BUSY: begin
        if (annul_i) begin
          state_d    = IDLE;
          div_zero_d = 1'b0;
        end else begin
          acc_d = iter_acc;
          lo_d  = iter_lo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_d = final_res;
            state_d  = DONE;
          end
        end
      end
      DIVZERO: begin
        state_d    = annul_i ? IDLE : DONE;
        div_zero_d = !annul_i;
        if (!annul_i) result_d = '0;
      end
      default: begin
        if (!start_i) begin
          state_d    = IDLE;
          div_zero_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      acc_q      <= '0;
      lo_q       <= '0;
      opb_q      <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      acc_q      <= acc_d;
      lo_q       <= lo_d;
      opb_q      <= opb_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = (state_q == DONE);
  assign busy_o     = (state_q == BUSY) || (state_q == DIVZERO);
  assign div_zero_o = div_zero_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed vectors, handshake/annul/reset sequences, and random ops vs a model.
module tb_mdu_iter;
  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;
  localparam int DZ_LAT  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_i = 1'b0;
  logic [1:0]     op_i = 2'd0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic           annul_i = 1'b0;
  logic [2*W-1:0] result_o;
  logic           ready_o, busy_o, div_zero_o;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o), .div_zero_o(div_zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mdu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'd0: return sa * sb;
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 0) return 64'd0;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return 64'd0;
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b);
    if (!op[1]) return MUL_LAT;
    if (b == 0) return DZ_LAT;
    return DIV_LAT;
  endfunction

  // Counts edges from the accepting edge (inclusive) until ready_o is seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output logic dz, output int lat, output int busy_n);
    @(negedge clk);
    start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b;
    lat = 0; busy_n = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (busy_o) begin
        busy_n++;
        op_i = 2'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
      end
    end while (!ready_o && lat < 100);
    res = result_o;
    dz  = div_zero_o;
  endtask

  task automatic release_start(input string name);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    check({name, "_ready_low"}, 64'(ready_o), 64'd0);
  endtask

  task automatic run_and_check(input string name, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] exp_res, input logic exp_dz,
                               input int exp_lat);
    logic [63:0] res;
    logic dz;
    int lat, busy_n;
    run_op(op, a, b, res, dz, lat, busy_n);
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_res"}, res, exp_res);
    check({name, "_dz"}, 64'(dz), 64'(exp_dz));
    check({name, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
    release_start(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] prev;
    int n, cnt;

    vecs[0]  = '{2'd3, 32'd100,        32'd7,        64'h00000002_0000000E, 1'b0, DIV_LAT};
    vecs[1]  = '{2'd2, 32'hFFFFFFF9,   32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0, DIV_LAT};
    vecs[2]  = '{2'd0, 32'hFFFFFFFD,   32'd5,        64'hFFFFFFFF_FFFFFFF1, 1'b0, MUL_LAT};
    vecs[3]  = '{2'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, MUL_LAT};
    vecs[4]  = '{2'd2, 32'd5,          32'd0,        64'h0,                 1'b1, DZ_LAT};
    vecs[5]  = '{2'd2, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, DIV_LAT};
    vecs[6]  = '{2'd3, 32'd9,          32'd3,        64'h00000000_00000003, 1'b0, DIV_LAT};
    vecs[7]  = '{2'd2, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, DIV_LAT};
    vecs[8]  = '{2'd3, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 1'b0, DIV_LAT};
    vecs[9]  = '{2'd0, 32'h80000000,   32'h80000000, 64'h40000000_00000000, 1'b0, MUL_LAT};
    vecs[10] = '{2'd3, 32'd0,          32'd0,        64'h0,                 1'b1, DZ_LAT};
    vecs[11] = '{2'd1, 32'h00010000,   32'h00010000, 64'h00000001_00000000, 1'b0, MUL_LAT};

    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result_o, 64'd0);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_dz", 64'(div_zero_o), 64'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].res, vecs[i].dz, vecs[i].lat);

    // Hold start after ready; annul in DONE must not disturb anything.
    run_and_check("hold_pre", 2'd3, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, DIV_LAT);
    prev = 64'h00000002_0000000E;
    begin
      logic [63:0] res; logic dz; int lat, busy_n;
      run_op(2'd3, 32'd100, 32'd7, res, dz, lat, busy_n);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        annul_i = (c == 0);
        opdata1_i = $urandom; opdata2_i = $urandom;
        @(posedge clk); #1;
        check("hold_ready", 64'(ready_o), 64'd1);
        check("hold_result", result_o, prev);
      end
      annul_i = 1'b0;
      release_start("hold");
      check("idle_keeps_result", result_o, prev);
    end

    // Annul mid-DIVU.
    @(negedge clk);
    start_i = 1'b1; op_i = 2'd3; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    check("annul_busy", 64'(busy_o), 64'd0);
    @(negedge clk); annul_i = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (ready_o) cnt++;
    end
    check("annul_no_ready", 64'(cnt), 64'd0);
    check("annul_result", result_o, prev);
    check("annul_dz", 64'(div_zero_o), 64'd0);

    // start with annul in IDLE is ignored.
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b1; op_i = 2'd2; opdata1_i = 32'd5; opdata2_i = 32'd0;
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (busy_o || ready_o) cnt++;
    end
    check("idle_annul_ignored", 64'(cnt), 64'd0);
    @(negedge clk); start_i = 1'b0; annul_i = 1'b0;

    // Annul in DIVZERO.
    @(negedge clk);
    start_i = 1'b1; op_i = 2'd2; opdata1_i = 32'd5; opdata2_i = 32'd0;
    @(posedge clk); #1;
    check("dz_annul_busy_before", 64'(busy_o), 64'd1);
    @(negedge clk); annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    check("dz_annul_ready", 64'(ready_o), 64'd0);
    check("dz_annul_dz", 64'(div_zero_o), 64'd0);
    check("dz_annul_busy", 64'(busy_o), 64'd0);
    check("dz_annul_result", result_o, prev);
    @(negedge clk); annul_i = 1'b0;

    // Reset in the middle of MULTU.
    @(negedge clk);
    start_i = 1'b1; op_i = 2'd1; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'hFFFFFFFF;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_result", result_o, 64'd0);
    check("rst_mid_ready", 64'(ready_o), 64'd0);
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_dz", 64'(div_zero_o), 64'd0);
    @(negedge clk); rst = 1'b0; start_i = 1'b0;
    run_and_check("post_rst_divu", 2'd3, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0, DIV_LAT);

    // Random operations against the arithmetic model.
    n = 40;
    for (int i = 0; i < n; i++) begin
      logic [1:0] op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: a = $urandom_range(0, 255);
        1: a = 32'h80000000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom_range(1, 16);
        default: b = $urandom;
      endcase
      run_and_check($sformatf("rnd%0d", i), op, a, b, ref_mdu(op, a, b),
                    (op[1] && b == 0), ref_lat(op, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
